// File: rtl/spart_pkg.sv
// Shared SPART definitions: baud select encoding, divisor constants for a
// 50 MHz clock with 16x oversampling, and the divisor-sequencer state type.
package spart_pkg;

    typedef enum logic [1:0] {
        BAUD_4800  = 2'b00,
        BAUD_9600  = 2'b01,
        BAUD_19200 = 2'b10,
        BAUD_38400 = 2'b11
    } baud_sel_t;

    localparam logic [15:0] DIV_4800  = 16'd651;
    localparam logic [15:0] DIV_9600  = 16'd326;
    localparam logic [15:0] DIV_19200 = 16'd163;
    localparam logic [15:0] DIV_38400 = 16'd81;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_DRAIN,
        ST_WR_LO,
        ST_WR_HI,
        ST_SETTLE,
        ST_ACK
    } baud_cfg_state_t;

    function automatic logic [15:0] baud_divisor(input baud_sel_t sel);
        logic [15:0] div;
        case (sel)
            BAUD_4800:  div = DIV_4800;
            BAUD_9600:  div = DIV_9600;
            BAUD_19200: div = DIV_19200;
            default:    div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/baud_config_ctrl.sv
// Programs the baud generator's 16-bit divisor as a low/high byte pair once
// TX and RX are idle; runs a boot programming sequence after every reset.
module baud_config_ctrl
    import spart_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter baud_sel_t   RESET_SEL     = BAUD_9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_req,
    input  logic [1:0] cfg_sel,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       cfg_ack,
    output logic       cfg_ready,
    output logic       busy,
    output logic       tx_hold,
    output logic [1:0] cur_sel,
    output logic       baud_write_en,
    output logic       baud_write_location,
    output logic [7:0] baud_generator_write_line
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    baud_cfg_state_t state;
    baud_cfg_state_t nxt_state;
    baud_sel_t       pending_sel;
    logic            from_req;
    logic [3:0]      settle_cnt;
    logic [15:0]     divisor;

    assign divisor = baud_divisor(pending_sel);

    always_comb begin
        nxt_state = state;
        case (state)
            ST_BOOT:   nxt_state = ST_DRAIN;
            ST_IDLE:   if (cfg_req) nxt_state = ST_DRAIN;
            ST_DRAIN:  if (!(tx_busy || rx_busy)) nxt_state = ST_WR_LO;
            ST_WR_LO:  nxt_state = ST_WR_HI;
            ST_WR_HI:  nxt_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt <= 4'd1) nxt_state = ST_ACK;
            ST_ACK:    nxt_state = ST_IDLE;
            default:   nxt_state = ST_BOOT;
        endcase
    end

    // Outputs are registered from the next state so each is valid for the
    // whole cycle of the state it belongs to, with no decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= ST_BOOT;
            pending_sel               <= RESET_SEL;
            from_req                  <= 1'b0;
            settle_cnt                <= 4'd0;
            cfg_ack                   <= 1'b0;
            cfg_ready                 <= 1'b0;
            busy                      <= 1'b1;
            tx_hold                   <= 1'b1;
            cur_sel                   <= RESET_SEL;
            baud_write_en             <= 1'b0;
            baud_write_location       <= 1'b0;
            baud_generator_write_line <= 8'h00;
        end else begin
            state <= nxt_state;

            if (state == ST_BOOT) begin
                pending_sel <= RESET_SEL;
                from_req    <= 1'b0;
            end else if (state == ST_IDLE && cfg_req) begin
                pending_sel <= baud_sel_t'(cfg_sel);
                from_req    <= 1'b1;
            end

            if (state == ST_WR_HI)
                settle_cnt <= SETTLE_LOAD;
            else if (state == ST_SETTLE)
                settle_cnt <= settle_cnt - 4'd1;

            busy    <= (nxt_state != ST_IDLE);
            tx_hold <= (nxt_state != ST_IDLE);

            baud_write_en       <= (nxt_state == ST_WR_LO) || (nxt_state == ST_WR_HI);
            baud_write_location <= (nxt_state == ST_WR_HI);
            if (nxt_state == ST_WR_LO)
                baud_generator_write_line <= divisor[7:0];
            else if (nxt_state == ST_WR_HI)
                baud_generator_write_line <= divisor[15:8];
            else
                baud_generator_write_line <= 8'h00;

            // A boot sequence completes silently; only requests are acknowledged.
            cfg_ack <= (nxt_state == ST_ACK) && from_req;
            if (nxt_state == ST_ACK) begin
                cur_sel   <= pending_sel;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baud_config_ctrl.sv
// Scoreboard bench for baud_config_ctrl: expected byte writes, acks and
// ready timing are derived from baud rates and queued for a negedge monitor.
module tb_baud_config_ctrl;

    localparam int S = 2;
    localparam int BOOT_SEL = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_req;
    logic [1:0] cfg_sel;
    logic       tx_busy;
    logic       rx_busy;
    logic       cfg_ack;
    logic       cfg_ready;
    logic       busy;
    logic       tx_hold;
    logic [1:0] cur_sel;
    logic       baud_write_en;
    logic       baud_write_location;
    logic [7:0] baud_generator_write_line;

    baud_config_ctrl #(
        .SETTLE_CYCLES(S),
        .RESET_SEL(spart_pkg::BAUD_9600)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_req(cfg_req),
        .cfg_sel(cfg_sel),
        .tx_busy(tx_busy),
        .rx_busy(rx_busy),
        .cfg_ack(cfg_ack),
        .cfg_ready(cfg_ready),
        .busy(busy),
        .tx_hold(tx_hold),
        .cur_sel(cur_sel),
        .baud_write_en(baud_write_en),
        .baud_write_location(baud_write_location),
        .baud_generator_write_line(baud_generator_write_line)
    );

    always #10 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        int cyc;
    } wr_exp_t;

    typedef struct {
        int sel;
        int cyc;
    } ack_exp_t;

    wr_exp_t  wr_q[$];
    ack_exp_t ack_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_exp = -1;
    int ready_sel = 0;
    int exp_cur = BOOT_SEL;
    int hi_exp = 0;
    logic hi_due = 1'b0;
    logic prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divisor from first principles: 50 MHz / (16 * baud), rounded to nearest.
    function automatic int model_div(input int sel);
        int baud;
        baud = 4800 << sel;
        return (50_000_000 + 8 * baud) / (16 * baud);
    endfunction

    task automatic push_seq(input int sel, input int c0, input int drain_len, input bit is_req);
        int d;
        wr_exp_t w;
        ack_exp_t a;
        d = model_div(sel);
        w.lo = d % 256;
        w.hi = d / 256;
        w.cyc = c0 + drain_len + 1;
        wr_q.push_back(w);
        if (is_req) begin
            a.sel = sel;
            a.cyc = c0 + drain_len + 3 + S;
            ack_q.push_back(a);
        end else begin
            ready_exp = c0 + drain_len + 3 + S;
            ready_sel = sel;
        end
        exp_cur = sel;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hi_due = 1'b0;
            prev_ready = cfg_ready;
        end else begin
            if (hi_due) begin
                checkOutput("wr_hi_en", baud_write_en, 1);
                checkOutput("wr_hi_loc", baud_write_location, 1);
                checkOutput("wr_hi_byte", baud_generator_write_line, hi_exp);
                hi_due = 1'b0;
            end else if (baud_write_en) begin
                if (wr_q.size() == 0) begin
                    checkOutput("wr_unexpected", baud_write_en, 0);
                end else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    checkOutput("wr_lo_loc", baud_write_location, 0);
                    checkOutput("wr_lo_byte", baud_generator_write_line, w.lo);
                    checkOutput("wr_lo_cycle", cyc, w.cyc);
                    hi_exp = w.hi;
                    hi_due = 1'b1;
                end
            end else begin
                checkOutput("idle_line", baud_generator_write_line, 0);
            end
            if (cfg_ack) begin
                if (ack_q.size() == 0) begin
                    checkOutput("ack_unexpected", cfg_ack, 0);
                end else begin
                    ack_exp_t a;
                    a = ack_q.pop_front();
                    checkOutput("ack_cur_sel", cur_sel, a.sel);
                    checkOutput("ack_cycle", cyc, a.cyc);
                end
            end
            if (cfg_ready && !prev_ready) begin
                checkOutput("ready_cycle", cyc, ready_exp);
                checkOutput("ready_cur_sel", cur_sel, ready_sel);
                checkOutput("ready_no_ack", cfg_ack, 0);
            end
            prev_ready = cfg_ready;
        end
    end

    task automatic check_reset(input string tag);
        checkOutput({tag, "_ack"}, cfg_ack, 0);
        checkOutput({tag, "_ready"}, cfg_ready, 0);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_tx_hold"}, tx_hold, 1);
        checkOutput({tag, "_cur_sel"}, cur_sel, BOOT_SEL);
        checkOutput({tag, "_wr_en"}, baud_write_en, 0);
        checkOutput({tag, "_wr_loc"}, baud_write_location, 0);
        checkOutput({tag, "_wr_line"}, baud_generator_write_line, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
        checkOutput("idle_reached", busy, 0);
    endtask

    task automatic wait_ack();
        @(negedge clk);
        for (int i = 0; i < 300 && cfg_ack !== 1'b1; i++) @(negedge clk);
        checkOutput("ack_seen", cfg_ack, 1);
    endtask

    task automatic applyStimulus(input int sel, input int stall, input bit use_rx);
        int c0;
        wait_idle();
        c0 = cyc;
        cfg_sel = 2'(sel);
        cfg_req = 1'b1;
        tx_busy = (stall > 0) && !use_rx;
        rx_busy = (stall > 0) && use_rx;
        push_seq(sel, c0, (stall > 1) ? stall : 1, 1'b1);
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk);
            checkOutput("drain_hold", tx_hold, 1);
            checkOutput("drain_no_wr", baud_write_en, 0);
        end
        tx_busy = 1'b0;
        rx_busy = 1'b0;
        wait_ack();
        cfg_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int ca;
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg_sel = 2'b00;
        tx_busy = 1'b0;
        rx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        push_seq(BOOT_SEL, cyc, 1, 1'b0);
        wait_idle();

        applyStimulus(3, 0, 1'b0);
        applyStimulus(0, 20, 1'b0);

        // Request while the controller is settling must be ignored.
        wait_idle();
        c0 = cyc;
        cfg_sel = 2'b00;
        cfg_req = 1'b1;
        push_seq(0, c0, 1, 1'b1);
        @(negedge clk);
        cfg_req = 1'b0;
        repeat (3) @(negedge clk);
        cfg_sel = 2'b10;
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        cfg_sel = 2'b00;
        wait_ack();
        repeat (10) @(negedge clk);
        checkOutput("settle_req_ignored", busy, 0);
        checkOutput("settle_cur_sel", cur_sel, 0);

        // Reset in the WR_LO cycle: boot must rewrite both bytes.
        wait_idle();
        cfg_sel = 2'b00;
        cfg_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_wr_lo", baud_generator_write_line, model_div(0) % 256);
        rst = 1'b1;
        cfg_req = 1'b0;
        #1;
        check_reset("mid_rst");
        wr_q.delete();
        ack_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_seq(BOOT_SEL, cyc, 1, 1'b0);
        wait_idle();

        // Request held through ack restarts after exactly one idle cycle.
        wait_idle();
        c0 = cyc;
        cfg_sel = 2'b11;
        cfg_req = 1'b1;
        push_seq(3, c0, 1, 1'b1);
        wait_ack();
        ca = cyc;
        push_seq(3, ca + 1, 1, 1'b1);
        @(negedge clk);
        checkOutput("gap_idle", busy, 0);
        @(negedge clk);
        checkOutput("gap_rebusy", busy, 1);
        wait_ack();
        cfg_req = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (5) @(negedge clk);
        checkOutput("wr_q_drained", wr_q.size(), 0);
        checkOutput("ack_q_drained", ack_q.size(), 0);
        checkOutput("final_cur_sel", cur_sel, exp_cur);
        checkOutput("final_ready", cfg_ready, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/baud_config_ctrl.md
# baud_config_ctrl

Sequencer that programs the SPART baud rate generator's 16-bit divisor through its byte-wide write port. It sits between the processor-side configuration logic and the baud generator. It maps a 2-bit baud select to a divisor, waits for the transmitter and receiver to go idle, and issues the low-byte then high-byte write. It then settles and acknowledges. On reset it automatically programs a boot rate.

## Interface
- SETTLE_CYCLES, default 2: idle cycles after the high-byte write before acknowledge; legal range 1–15.
- RESET_SEL, default 2'b01 (9600): baud select programmed automatically after reset.

- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-high.
- cfg_req  in  1  configuration request, level; sampled only in IDLE.
- cfg_sel  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400; must be held stable while cfg_req is high.
- tx_busy  in  1  transmitter mid-frame.
- rx_busy  in  1  receiver mid-frame.
- cfg_ack  out  1  single-cycle pulse: requested divisor is fully written.
- cfg_ready  out  1  at least one complete configuration (boot or requested) has been written since reset.
- busy  out  1  controller is not in IDLE.
- tx_hold  out  1  transmitter must not start a new frame.
- cur_sel  out  2  select currently programmed.
- baud_write_en  out  1  write strobe to the baud generator.
- baud_write_location  out  1  0 = divisor low byte, 1 = divisor high byte.
- baud_generator_write_line  out  8  divisor byte.

## Operation
- Divisor map, for 50 MHz with 16× oversampling:
  - 00 → 651 (0x028B)
  - 01 → 326 (0x0146)
  - 10 → 163 (0x00A3)
  - 11 → 81 (0x0051)
- States: BOOT, IDLE, DRAIN, WR_LO, WR_HI, SETTLE, ACK.
- BOOT: entered from reset. Latches RESET_SEL as the pending select, then moves to DRAIN on the next edge.
- IDLE: if cfg_req=1, latches cfg_sel as pending and moves to DRAIN; otherwise stays.
- DRAIN: tx_hold=1. Stays while tx_busy|rx_busy; otherwise moves to WR_LO. There is no timeout.
- WR_LO: baud_write_en=1, location=0, line=divisor[7:0]. Lasts one cycle, then WR_HI.
- WR_HI: baud_write_en=1, location=1, line=divisor[15:8]. Lasts one cycle, then SETTLE.
- SETTLE: tx_hold=1 for exactly SETTLE_CYCLES cycles (4-bit down-counter), then ACK.
- ACK: one cycle. cur_sel ← pending and cfg_ready ← 1 on entry.
  - cfg_ack=1 only if the sequence came from a request; a boot sequence does not pulse cfg_ack.
  - Then moves to IDLE.
- Outside WR_LO/WR_HI: baud_write_en=0, location=0, line=0x00.
- busy=1 in every state except IDLE. tx_hold=1 in BOOT, DRAIN, WR_LO, WR_HI, SETTLE, ACK.
- Requests arriving while busy are not queued. cfg_sel is not re-sampled until IDLE.
- Handshake: the requester holds cfg_req until it sees cfg_ack, then drops it. If cfg_req is still high in the first IDLE cycle, a new sequence starts; this is legal behaviour.
- Requesting the select already in cur_sel still performs the full write sequence.

## Timing
- Reset values: state BOOT, cfg_ack 0, cfg_ready 0, busy 1, tx_hold 1, cur_sel RESET_SEL, baud_write_en 0, baud_write_location 0, baud_generator_write_line 0x00, settle counter 0.
- Outputs are registered or decoded purely from state. They are glitch-free and valid for the whole cycle of their state.
- Latency with idle TX/RX: request sampled at edge E0. DRAIN in cycle 1, WR_LO in cycle 2, WR_HI in cycle 3, SETTLE in cycles 4…3+S, cfg_ack in cycle 4+S. That is cycle 6 at the default S=2.
- Boot after reset release: WR_LO in cycle 2, WR_HI in cycle 3, cfg_ready=1 from cycle 4+S.
- Low and high writes occur in consecutive cycles and are never separated.
- Reset mid-sequence, including between WR_LO and WR_HI: all outputs return to reset values at once. The boot sequence then rewrites both bytes, so a half-written divisor never persists.
- tx_busy dropping and cfg_req rising in the same cycle as IDLE: the request is accepted, and DRAIN passes in one cycle.

## Structure
- Shared package spart_pkg holds:
  - baud_sel_t, a 2-bit enum.
  - Divisor constants DIV_4800, DIV_9600, DIV_19200, DIV_38400.
  - Function baud_divisor(baud_sel_t) returning 16 bits.
  - The state enum for this controller.
- Single module with no sub-modules. The divisor lookup is the package function, so it is reused by the testbench.

## Test plan
- Reset release, TX/RX idle, default parameters:
  - Writes 0x46 (loc 0) in cycle 2 and 0x01 (loc 1) in cycle 3.
  - cfg_ready rises in cycle 6, no cfg_ack, cur_sel=01.
- From IDLE, cfg_req with cfg_sel=11: writes 0x51 then 0x00, cfg_ack pulses exactly 6 cycles after the sample edge, cur_sel=11.
- cfg_sel=00 with tx_busy held high for 20 cycles:
  - Stays in DRAIN with tx_hold=1 and no writes.
  - After release, writes 0x8B then 0x02 back-to-back.
- cfg_req toggled with cfg_sel=10 during SETTLE: ignored. The only sequence performed is the one already in progress, and exactly one cfg_ack pulses.
- rst asserted in WR_LO cycle of a 4800 request:
  - Outputs go to reset values immediately.
  - The boot sequence rewrites 0x46/0x01, and cfg_ack never pulses.
- cfg_req held high through cfg_ack: a second full sequence starts in the first IDLE cycle, and busy drops for only that one cycle.
